// File: rtl/uart_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_arb_pkg: state encoding and width helper for uart_tx_arbiter         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_IDLE = 2'd3
   } arb_state_e;

   // Bits needed to index 'value' distinct items (0 for value <= 1).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick: combinational round-robin select, searching ptr+1, ptr+2, ...   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = clog2(N_REQ)
)(
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             any_o,
   output logic [IDX_W-1:0] idx_o,
   output logic [N_REQ-1:0] onehot_o
);

   logic [IDX_W-1:0] w_pos;

   // Walk from the farthest offset to the nearest so the nearest hit wins.
   always_comb begin
      any_o    = 1'b0;
      idx_o    = '0;
      onehot_o = '0;
      w_pos    = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         w_pos = IDX_W'((int'(ptr_i) + k) % N_REQ);
         if (req_i[w_pos]) begin
            any_o = 1'b1;
            idx_o = w_pos;
         end
      end
      if (any_o) onehot_o = N_REQ'(1) << idx_o;
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_arbiter: shares one buart transmitter among N_REQ byte sources.  |
// | Optional packet locking with UART_ARB_LOCK_EN.   Revision: 1.0           |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int W_DATA    = 8,
   parameter int BUSY_WAIT = 15
)(
   input  logic                    clk,
   input  logic                    resetq,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*W_DATA-1:0] req_data,
   input  logic [N_REQ-1:0]        req_last,
   output logic [N_REQ-1:0]        req_ready,
   output logic [N_REQ-1:0]        grant,
   output logic                    uart_wr,
   output logic [W_DATA-1:0]       uart_tx_data,
   input  logic                    uart_busy,
   output logic                    timeout_err
);

   localparam int c_IDX_W = clog2(N_REQ);
   localparam int c_CNT_W = clog2(BUSY_WAIT + 1);

   arb_state_e          r_state_q, w_state_d;
   logic [N_REQ-1:0]    r_ready_q, w_ready_d;
   logic [N_REQ-1:0]    r_grant_q, w_grant_d;
   logic                r_wr_q, w_wr_d;
   logic [W_DATA-1:0]   r_data_q, w_data_d;
   logic [c_IDX_W-1:0]  r_ptr_q, w_ptr_d;
   logic [c_CNT_W-1:0]  r_cnt_q, w_cnt_d;
   logic                r_tout_q, w_tout_d;

   logic [W_DATA-1:0]   w_req_byte [N_REQ];
   logic [N_REQ-1:0]    w_eligible;
   logic                w_any;
   logic [c_IDX_W-1:0]  w_idx;
   logic [N_REQ-1:0]    w_onehot;
   logic                w_capture;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_req_byte[gi] = req_data[gi*W_DATA +: W_DATA];
   end

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (c_IDX_W)
   ) u_rr_pick (
      .req_i    (w_eligible),
      .ptr_i    (r_ptr_q),
      .any_o    (w_any),
      .idx_o    (w_idx),
      .onehot_o (w_onehot)
   );

   assign w_capture = (r_state_q == IDLE) && !uart_busy && w_any;

`ifdef UART_ARB_LOCK_EN
   logic             r_lock_q, w_lock_d;
   logic [N_REQ-1:0] r_lock_mask_q, w_lock_mask_d;

   // A non-final byte pins the arbiter to its owner until that owner sends a last byte.
   always_comb begin
      w_lock_d      = r_lock_q;
      w_lock_mask_d = r_lock_mask_q;
      if (w_capture) begin
         w_lock_d      = ~req_last[w_idx];
         w_lock_mask_d = w_onehot;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetq) begin
         r_lock_q      <= 1'b0;
         r_lock_mask_q <= '0;
      end else begin
         r_lock_q      <= w_lock_d;
         r_lock_mask_q <= w_lock_mask_d;
      end
   end

   assign w_eligible = r_lock_q ? (req_valid & r_lock_mask_q) : req_valid;
`else
   logic w_unused_last;
   assign w_unused_last = ^req_last;
   assign w_eligible    = req_valid;
`endif

   always_comb begin
      w_state_d = r_state_q;
      w_ready_d = '0;
      w_wr_d    = 1'b0;
      w_grant_d = r_grant_q;
      w_data_d  = r_data_q;
      w_ptr_d   = r_ptr_q;
      w_cnt_d   = r_cnt_q;
      w_tout_d  = r_tout_q;
      case (r_state_q)
         IDLE: begin
            if (w_capture) begin
               w_data_d  = w_req_byte[w_idx];
               w_wr_d    = 1'b1;
               w_ready_d = w_onehot;
               w_grant_d = w_onehot;
               w_ptr_d   = w_idx;
               w_state_d = WRITE;
            end
         end
         WRITE: begin
            w_cnt_d   = '0;
            w_state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (uart_busy) begin
               w_state_d = WAIT_IDLE;
            end else begin
               w_cnt_d = r_cnt_q + c_CNT_W'(1);
               if (w_cnt_d == c_CNT_W'(BUSY_WAIT)) begin
                  w_tout_d  = 1'b1;
                  w_grant_d = '0;
                  w_state_d = IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (!uart_busy) begin
               w_grant_d = '0;
               w_state_d = IDLE;
            end
         end
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetq) begin
         r_state_q <= IDLE;
         r_ready_q <= '0;
         r_grant_q <= '0;
         r_wr_q    <= 1'b0;
         r_data_q  <= '0;
         r_ptr_q   <= c_IDX_W'(N_REQ - 1);
         r_cnt_q   <= '0;
         r_tout_q  <= 1'b0;
      end else begin
         r_state_q <= w_state_d;
         r_ready_q <= w_ready_d;
         r_grant_q <= w_grant_d;
         r_wr_q    <= w_wr_d;
         r_data_q  <= w_data_d;
         r_ptr_q   <= w_ptr_d;
         r_cnt_q   <= w_cnt_d;
         r_tout_q  <= w_tout_d;
      end
   end

   assign req_ready    = r_ready_q;
   assign grant        = r_grant_q;
   assign uart_wr      = r_wr_q;
   assign uart_tx_data = r_data_q;
   assign timeout_err  = r_tout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_arbiter: directed scoreboard bench with a buart busy model     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int BW = 15;

   logic           clk = 1'b0;
   logic           resetq = 1'b0;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   grant;
   logic           uart_wr;
   logic [W-1:0]   uart_tx_data;
   logic           uart_busy;
   logic           timeout_err;

   uart_tx_arbiter #(
      .N_REQ     (N),
      .W_DATA    (W),
      .BUSY_WAIT (BW)
   ) dut (
      .clk          (clk),
      .resetq       (resetq),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .grant        (grant),
      .uart_wr      (uart_wr),
      .uart_tx_data (uart_tx_data),
      .uart_busy    (uart_busy),
      .timeout_err  (timeout_err)
   );

   always #4 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   int   exp_q[$];
   logic [7:0] rdat  [N][16];
   logic       rlast [N][16];
   int   rhead [N];
   int   rtail [N];
   logic stuck = 1'b0;
   int   bdly  = 0;
   int   bhold = 0;
   logic prev_wr = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_wait(input string nm);
      n_checks++;
      n_errors++;
      $display("FAIL %s: wait expired before the expected event", nm);
   endtask

   task automatic load(input int i, input logic [7:0] d, input logic l);
      rdat[i][rtail[i] % 16]  = d;
      rlast[i][rtail[i] % 16] = l;
      rtail[i]++;
   endtask

   task automatic exp_byte(input int i, input logic [7:0] d);
      exp_q.push_back(i * 256 + int'(d));
   endtask

   task automatic wait_drain(input string nm);
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && grant == '0 && !uart_busy && req_valid == '0) return;
      end
      fail_wait(nm);
   endtask

   // Requesters: hold valid/data until ready, advance on the following edge.
   initial begin
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (req_ready[i] && rhead[i] != rtail[i]) rhead[i]++;
            if (rhead[i] != rtail[i]) begin
               req_valid[i]       = 1'b1;
               req_data[i*W +: W] = rdat[i][rhead[i] % 16];
               req_last[i]        = rlast[i][rhead[i] % 16];
            end else begin
               req_valid[i]       = 1'b0;
               req_data[i*W +: W] = '0;
               req_last[i]        = 1'b0;
            end
         end
      end
   end

   // buart model: busy rises 2 cycles after wr and stays high 100 cycles.
   initial begin
      uart_busy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!resetq) begin
            uart_busy = 1'b0;
            bdly      = 0;
            bhold     = 0;
         end else if (uart_wr && !stuck) begin
            bdly = 2;
         end else if (bdly > 0) begin
            bdly--;
            if (bdly == 0) begin
               uart_busy = 1'b1;
               bhold     = 100;
            end
         end else if (bhold > 0) begin
            bhold--;
            if (bhold == 0) uart_busy = 1'b0;
         end
      end
   end

   // Monitor: every wr pulse is checked against the next scoreboard entry.
   initial begin
      int e;
      forever begin
         @(negedge clk);
         if (uart_wr) begin
            chk("wr_single_cycle", 32'(prev_wr), 32'd0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_wr: got grant %b data %h expected no write", grant, uart_tx_data);
            end else begin
               e = exp_q.pop_front();
               chk("wr_data",  32'(uart_tx_data), 32'(e % 256));
               chk("wr_grant", 32'(grant),        32'd1 << (e / 256));
               chk("wr_ready", 32'(req_ready),    32'd1 << (e / 256));
            end
         end else if (req_ready != '0) begin
            n_checks++;
            n_errors++;
            $display("FAIL stray_ready: got %b expected 0 outside a write", req_ready);
         end
         prev_wr = uart_wr;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int n;

      // Reset with every requester valid; then round-robin from req 0.
      resetq = 1'b0;
      for (int i = 0; i < N; i++) begin
         load(i, 8'h10 + 8'(i), 1'b1);
         load(i, 8'h20 + 8'(i), 1'b1);
      end
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < N; i++)
            exp_byte(i, (k == 0 ? 8'h10 : 8'h20) + 8'(i));
      repeat (5) begin
         @(negedge clk);
         chk("rst_wr",    32'(uart_wr),     32'd0);
         chk("rst_grant", 32'(grant),       32'd0);
         chk("rst_ready", 32'(req_ready),   32'd0);
         chk("rst_tout",  32'(timeout_err), 32'd0);
      end
      resetq = 1'b1;
      wait_drain("drain_rr");

      // Single requester; grant held until busy falls.
      exp_byte(1, 8'h41);
      load(1, 8'h41, 1'b1);
      ok = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (uart_busy) begin ok = 1; break; end
      end
      if (!ok) fail_wait("single_busy_rise");
      else chk("single_grant_busy", 32'(grant), 32'h2);
      ok = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (!uart_busy) begin ok = 1; break; end
      end
      if (!ok) fail_wait("single_busy_fall");
      else begin
         chk("single_grant_hold", 32'(grant), 32'h2);
         @(negedge clk);
         chk("single_grant_release", 32'(grant), 32'h0);
      end
      wait_drain("drain_single");

      // Busy never rises: timeout after BW cycles in WAIT_BUSY, next byte still served.
      stuck = 1'b1;
      exp_byte(1, 8'h55);
      load(1, 8'h55, 1'b1);
      ok = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (uart_wr) begin ok = 1; break; end
      end
      if (!ok) fail_wait("timeout_wr");
      else begin
         n = 0;
         while (!timeout_err && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk("timeout_latency", 32'(n), 32'(BW + 1));
         chk("timeout_grant",   32'(grant), 32'h0);
      end
      stuck = 1'b0;
      exp_byte(3, 8'h77);
      load(3, 8'h77, 1'b1);
      wait_drain("drain_timeout");
      chk("timeout_sticky", 32'(timeout_err), 32'd1);

      // req2 sends a 3-byte packet with a head start; req0 then stays valid.
`ifdef UART_ARB_LOCK_EN
      exp_byte(2, 8'hA0); exp_byte(2, 8'hA1); exp_byte(2, 8'hA2);
      exp_byte(0, 8'hC0); exp_byte(0, 8'hC1);
`else
      exp_byte(2, 8'hA0); exp_byte(0, 8'hC0); exp_byte(2, 8'hA1);
      exp_byte(0, 8'hC1); exp_byte(2, 8'hA2);
`endif
      load(2, 8'hA0, 1'b0);
      load(2, 8'hA1, 1'b0);
      load(2, 8'hA2, 1'b1);
      ok = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (grant == 4'b0100) begin ok = 1; break; end
      end
      if (!ok) fail_wait("lock_first_grant");
      load(0, 8'hC0, 1'b1);
      load(0, 8'hC1, 1'b1);
      wait_drain("drain_lock");

      // Reset while waiting for busy to fall; lock and pointer must restart.
      exp_byte(2, 8'hB0);
      load(2, 8'hB0, 1'b0);
      ok = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (uart_busy) begin ok = 1; break; end
      end
      if (!ok) fail_wait("midrst_busy");
      @(negedge clk);
      resetq = 1'b0;
      @(negedge clk);
      chk("midrst_grant", 32'(grant),       32'd0);
      chk("midrst_wr",    32'(uart_wr),     32'd0);
      chk("midrst_ready", 32'(req_ready),   32'd0);
      chk("midrst_tout",  32'(timeout_err), 32'd0);
      resetq = 1'b1;
      exp_byte(0, 8'hC4);
      exp_byte(2, 8'hC6);
      load(0, 8'hC4, 1'b1);
      load(2, 8'hC6, 1'b1);
      wait_drain("drain_midrst");

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
